reg_bank_arbiter: RTL and testbench
===================================

# reg_bank_arbiter

Two-port arbitrated register bank for the HACK datapath: DEPTH words of WIDTH-bit storage, each a load-enabled register, shared between requester A (CPU side) and requester B (loader/debug side). A three-state sequencer serialises accesses, grants in round-robin order, and returns read data with a one-cycle grant pulse. This block is the single owner of the bank's load strobes; no other logic writes the words.

## Interface
- WIDTH, 16, data word width
- DEPTH, 8, number of words in the bank
- ADDR_W, 3, address width; must satisfy 2^ADDR_W >= DEPTH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_a / req_b  in  1  access request, held until the matching gnt
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  ADDR_W  word address
- wdata_a / wdata_b  in  WIDTH  write data
- gnt_a / gnt_b  out  1  one-cycle completion pulse
- rdata_a / rdata_b  out  WIDTH  response data, valid while the matching gnt is high
- busy  out  1  high when the FSM is not in IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if neither req is high, stay. If exactly one is high, that requester wins. If both are high, the winner is the one selected by the priority pointer `ptr` (0 = A). Latch the winner's id, we, addr, and wdata, then go to ACCESS.
- ACCESS, write with addr < DEPTH: assert the load strobe of word[addr] for exactly this cycle, with data = latched wdata.
- ACCESS, read with addr < DEPTH: capture word[addr] into the response register.
- ACCESS, addr >= DEPTH: no write occurs and the response is 0.
- ACCESS: go to RESP.
- RESP: pulse gnt of the latched winner; drive the response on that requester's rdata. For a write, the response is the newly written value. Set ptr to the other requester. Go to IDLE.
- Only the winner's rdata updates. The loser's rdata holds its previous value. gnt_a and gnt_b are never high together.
- Requester fields are sampled only in IDLE. Changes while the block is busy are ignored.
- A req dropped before its gnt is a protocol violation: the latched access still completes and gnt still pulses.
- A requester may keep req high after gnt. It is then re-arbitrated in the next IDLE cycle against the other requester; round-robin prevents starvation.

## Timing
- Request latency: req sampled high in IDLE at edge N gives ACCESS in cycle N+1, gnt high in cycle N+2, and IDLE again at N+3.
- Throughput: one access per 3 cycles.
- The write lands in storage on the edge that ends ACCESS. A read issued immediately afterwards by either requester sees the new value.
- Reset values:
  - state = IDLE, ptr = 0 (A)
  - all words = 0
  - gnt_a = gnt_b = 0
  - rdata_a = rdata_b = 0
  - busy = 0
- Reset mid-operation (rst_n low in ACCESS or RESP): the access is aborted, no gnt is issued, and the bank is cleared. The requester must re-issue after rst_n rises. The first edge with rst_n high evaluates IDLE normally.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Shared package `hack_pkg`:
  - WIDTH/DEPTH defaults
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - requester id constants (REQ_A=0, REQ_B=1)
- Sub-module `word_reg`: one WIDTH-bit register with data, load, clk, rst_n, out.
  - Clears to 0 on reset; captures data on a clk edge when load is high.
  - Instantiated DEPTH times in a generate loop.
- The arbiter/FSM, latches, and response registers live in reg_bank_arbiter itself.

## Test plan
- Reset check: assert rst_n=0, release, then A reads each addr 0..7 → each gnt_a arrives 2 cycles after the request is sampled, with rdata_a=16'h0000.
- Single requester: A writes 16'hBEEF to addr 3, then reads addr 3 → the write gnt_a shows rdata_a=16'hBEEF, and the read returns 16'hBEEF. busy is high for exactly 2 cycles per access.
- Simultaneous requests:
  - Stimulus: right after reset, A writes 16'h1111 to addr 5 and B writes 16'h2222 to addr 5, both held.
  - Order: A is granted first (ptr=0), B second.
  - Final word[5] = 16'h2222. gnt_a and gnt_b never overlap.
- Fairness: A and B both hold req continuously for 6 accesses → grants alternate A,B,A,B,A,B, each gnt 3 cycles apart.
- Reset mid-operation: A writes 16'hCAFE to addr 1 and rst_n drops during ACCESS → no gnt_a. A later read of addr 1 returns 16'h0000.
- Out-of-range access: with DEPTH=6 and ADDR_W=3, A writes 16'h7777 to addr 6 → gnt_a arrives with rdata_a=0. Words 0..5 are unchanged, and a read of addr 6 returns 0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the HACK datapath register bank: default sizes,
// sequencer state encoding and requester identifiers.
package hack_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/word_reg.sv
// One load-enabled storage word of the register bank; clears to zero on reset.
module word_reg
  import hack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] out
);

  // Storage word: capture data on load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= {WIDTH{1'b0}};
    end else if (load) begin
      out <= data;
    end else begin
      out <= out;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-port round-robin arbitrated register bank: IDLE/ACCESS/RESP sequencer,
// request latches, registered grant pulses and per-port response data.
module reg_bank_arbiter
  import hack_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  wdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  state_e              state_r;
  state_e              state_nx_s;
  logic                ptr_r;
  logic                win_id_r;
  logic                win_we_r;
  logic [ADDR_W-1:0]   win_addr_r;
  logic [WIDTH-1:0]    win_wdata_r;
  logic                any_req_s;
  logic                pick_s;
  logic                in_range_s;
  logic [DEPTH-1:0]    load_s;
  logic [WIDTH-1:0]    words_s [DEPTH];
  logic [WIDTH-1:0]    rd_word_s;
  logic [WIDTH-1:0]    resp_s;
  logic                gnt_a_r;
  logic                gnt_b_r;
  logic [WIDTH-1:0]    rdata_a_r;
  logic [WIDTH-1:0]    rdata_b_r;
  logic                busy_r;

  // Arbitration: a lone requester wins, a tie goes to the pointer
  always_comb begin
    any_req_s = req_a | req_b;
    if (req_a && req_b) begin
      pick_s = ptr_r;
    end else if (req_a) begin
      pick_s = REQ_A;
    end else begin
      pick_s = REQ_B;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nx_s = ST_ACCESS;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_nx_s = ST_RESP;
      ST_RESP:   state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Winner latch: requester fields are only observed while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_id_r    <= REQ_A;
      win_we_r    <= 1'b0;
      win_addr_r  <= {ADDR_W{1'b0}};
      win_wdata_r <= {WIDTH{1'b0}};
    end else if ((state_r == ST_IDLE) && any_req_s) begin
      win_id_r    <= pick_s;
      win_we_r    <= (pick_s == REQ_A) ? we_a    : we_b;
      win_addr_r  <= (pick_s == REQ_A) ? addr_a  : addr_b;
      win_wdata_r <= (pick_s == REQ_A) ? wdata_a : wdata_b;
    end else begin
      win_id_r    <= win_id_r;
      win_we_r    <= win_we_r;
      win_addr_r  <= win_addr_r;
      win_wdata_r <= win_wdata_r;
    end
  end

  assign in_range_s = ({1'b0, win_addr_r} < DEPTH_W);

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign load_s[i] = (state_r == ST_ACCESS) && win_we_r && in_range_s &&
                       (win_addr_r == ADDR_W'(i));
    word_reg #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_s[i]),
      .data  (win_wdata_r),
      .out   (words_s[i])
    );
  end

  // Response value: written data for writes, stored word for reads, zero out of range
  always_comb begin
    rd_word_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (win_addr_r == ADDR_W'(i)) begin
        rd_word_s = words_s[i];
      end else begin
        rd_word_s = rd_word_s;
      end
    end
    if (!in_range_s) begin
      resp_s = {WIDTH{1'b0}};
    end else if (win_we_r) begin
      resp_s = win_wdata_r;
    end else begin
      resp_s = rd_word_s;
    end
  end

  // Output registers; the pointer flips to the other requester after each grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_a_r   <= 1'b0;
      gnt_b_r   <= 1'b0;
      rdata_a_r <= {WIDTH{1'b0}};
      rdata_b_r <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      ptr_r     <= REQ_A;
    end else begin
      gnt_a_r <= (state_r == ST_ACCESS) && (win_id_r == REQ_A);
      gnt_b_r <= (state_r == ST_ACCESS) && (win_id_r == REQ_B);
      busy_r  <= (state_nx_s != ST_IDLE);
      if ((state_r == ST_ACCESS) && (win_id_r == REQ_A)) begin
        rdata_a_r <= resp_s;
      end else begin
        rdata_a_r <= rdata_a_r;
      end
      if ((state_r == ST_ACCESS) && (win_id_r == REQ_B)) begin
        rdata_b_r <= resp_s;
      end else begin
        rdata_b_r <= rdata_b_r;
      end
      if (state_r == ST_RESP) begin
        ptr_r <= ~win_id_r;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  assign gnt_a   = gnt_a_r;
  assign gnt_b   = gnt_b_r;
  assign rdata_a = rdata_a_r;
  assign rdata_b = rdata_b_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: a DEPTH=8 and a DEPTH=6 instance run in lock-step
// on shared requests, checked against a transaction-level bank model.
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [2:0]  addr_a = 3'd0, addr_b = 3'd0;
  logic [15:0] wdata_a = 16'h0000, wdata_b = 16'h0000;
  logic        gnt_a8, gnt_b8, busy8, gnt_a6, gnt_b6, busy6;
  logic [15:0] rdata_a8, rdata_b8, rdata_a6, rdata_b6;

  int n_tests = 0;
  int n_fail  = 0;

  // bank model state
  logic [15:0] mem8 [8];
  logic [15:0] mem6 [8];
  logic        ptr_m;
  logic [15:0] last_ra8, last_rb8, last_ra6, last_rb6;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a8), .gnt_b(gnt_b8), .rdata_a(rdata_a8), .rdata_b(rdata_b8),
    .busy(busy8));

  reg_bank_arbiter #(.WIDTH(16), .DEPTH(6), .ADDR_W(3)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a6), .gnt_b(gnt_b6), .rdata_a(rdata_a6), .rdata_b(rdata_b6),
    .busy(busy6));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // one access against a bank of depth 6 or 8
  task automatic model_acc(input bit six, input logic we, input logic [2:0] ad,
                           input logic [15:0] d, output logic [15:0] r);
    int dep;
    dep = six ? 6 : 8;
    if (int'(ad) >= dep) r = 16'h0000;
    else if (six) begin
      if (we) mem6[ad] = d;
      r = mem6[ad];
    end else begin
      if (we) mem8[ad] = d;
      r = mem8[ad];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    chk1("rst_gnt_a8", gnt_a8, 1'b0); chk1("rst_gnt_b8", gnt_b8, 1'b0);
    chk1("rst_busy8", busy8, 1'b0);   chk1("rst_busy6", busy6, 1'b0);
    chk("rst_rdata_a8", rdata_a8, 16'h0000); chk("rst_rdata_b8", rdata_b8, 16'h0000);
    chk("rst_rdata_a6", rdata_a6, 16'h0000); chk("rst_rdata_b6", rdata_b6, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem8[i] = 16'h0000;
      mem6[i] = 16'h0000;
    end
    ptr_m = 1'b0;
    last_ra8 = 16'h0000; last_rb8 = 16'h0000; last_ra6 = 16'h0000; last_rb6 = 16'h0000;
    @(posedge clk); #1;
  endtask

  // Starts in IDLE just after an edge; issues A and/or B, each dropped at its grant.
  task automatic do_round(input logic a_en, input logic a_we, input logic [2:0] a_ad,
                          input logic [15:0] a_d, input logic b_en, input logic b_we,
                          input logic [2:0] b_ad, input logic [15:0] b_d,
                          output logic [15:0] oa8, output logic [15:0] ob8,
                          output logic [15:0] oa6, output logic [15:0] ob6);
    logic        two, first, gid;
    logic [15:0] e8 [2];
    logic [15:0] e6 [2];
    int          gi, ncyc;
    oa8 = 16'h0000; ob8 = 16'h0000; oa6 = 16'h0000; ob6 = 16'h0000;
    two   = a_en && b_en;
    first = two ? ptr_m : (a_en ? 1'b0 : 1'b1);
    for (int k = 0; k < (two ? 2 : 1); k++) begin
      gid = (k == 0) ? first : ~first;
      if (gid == 1'b0) begin
        model_acc(1'b0, a_we, a_ad, a_d, e8[k]);
        model_acc(1'b1, a_we, a_ad, a_d, e6[k]);
      end else begin
        model_acc(1'b0, b_we, b_ad, b_d, e8[k]);
        model_acc(1'b1, b_we, b_ad, b_d, e6[k]);
      end
    end
    req_a = a_en; we_a = a_we; addr_a = a_ad; wdata_a = a_d;
    req_b = b_en; we_b = b_we; addr_b = b_ad; wdata_b = b_d;
    ncyc = two ? 5 : 2;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        if (first == 1'b0) {we_a, addr_a, wdata_a} = 20'($urandom);
        else               {we_b, addr_b, wdata_b} = 20'($urandom);
      end
      gi  = (c == 2) ? 0 : ((c == 5) ? 1 : -1);
      gid = (gi == 1) ? ~first : first;
      chk1("gnt_a8", gnt_a8, (gi >= 0) && (gid == 1'b0));
      chk1("gnt_b8", gnt_b8, (gi >= 0) && (gid == 1'b1));
      chk1("gnt_a6", gnt_a6, (gi >= 0) && (gid == 1'b0));
      chk1("gnt_b6", gnt_b6, (gi >= 0) && (gid == 1'b1));
      chk1("busy8", busy8, c != 3);
      chk1("busy6", busy6, c != 3);
      if (gi >= 0) begin
        if (gid == 1'b0) begin
          chk("rdata_a8", rdata_a8, e8[gi]); chk("rdata_a6", rdata_a6, e6[gi]);
          chk("hold_rdata_b8", rdata_b8, last_rb8); chk("hold_rdata_b6", rdata_b6, last_rb6);
          oa8 = rdata_a8; oa6 = rdata_a6;
          last_ra8 = e8[gi]; last_ra6 = e6[gi];
          req_a = 1'b0;
        end else begin
          chk("rdata_b8", rdata_b8, e8[gi]); chk("rdata_b6", rdata_b6, e6[gi]);
          chk("hold_rdata_a8", rdata_a8, last_ra8); chk("hold_rdata_a6", rdata_a6, last_ra6);
          ob8 = rdata_b8; ob6 = rdata_b6;
          last_rb8 = e8[gi]; last_rb6 = e6[gi];
          req_b = 1'b0;
        end
        ptr_m = ~gid;
      end
    end
    @(posedge clk); #1;
    chk1("idle_busy8", busy8, 1'b0);
    chk1("idle_gnt_a8", gnt_a8, 1'b0);
    chk1("idle_gnt_b8", gnt_b8, 1'b0);
  endtask

  typedef struct {
    bit          rst;
    bit          a_en;
    bit          a_we;
    logic [2:0]  a_ad;
    logic [15:0] a_d;
    bit          b_en;
    bit          b_we;
    logic [2:0]  b_ad;
    logic [15:0] b_d;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [13];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] oa8, ob8, oa6, ob6;
    logic        a_en, b_en, first;
    logic [15:0] e8, e6;
    int          gi;

    vecs[0]  = '{1'b1, 1'b1, 1'b1, 3'd5, 16'h1111, 1'b1, 1'b1, 3'd5, 16'h2222, 16'h1111, 16'h2222};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd5, 16'h0000, 16'h0000, 16'h2222};
    for (int i = 0; i < 8; i++) begin
      vecs[2 + i] = '{(i == 0), 1'b1, 1'b0, 3'(i), 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000,
                      16'h0000, 16'h0000};
    end
    vecs[10] = '{1'b0, 1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0, 3'd0, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd3, 16'h0000, 16'h0000, 16'hBEEF};

    do_reset();

    // directed table; word 5 ends as 16'h2222 after the tie, B's write landing second
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) do_reset();
      do_round(vecs[i].a_en, vecs[i].a_we, vecs[i].a_ad, vecs[i].a_d,
               vecs[i].b_en, vecs[i].b_we, vecs[i].b_ad, vecs[i].b_d, oa8, ob8, oa6, ob6);
      if (vecs[i].a_en) begin
        chk($sformatf("vec%0d_a8", i), oa8, vecs[i].exp_a);
        chk($sformatf("vec%0d_a6", i), oa6, vecs[i].exp_a);
      end
      if (vecs[i].b_en) begin
        chk($sformatf("vec%0d_b8", i), ob8, vecs[i].exp_b);
        chk($sformatf("vec%0d_b6", i), ob6, vecs[i].exp_b);
      end
    end

    // out-of-range write on the DEPTH=6 bank
    do_round(1'b1, 1'b1, 3'd6, 16'h7777, 1'b0, 1'b0, 3'd0, 16'h0000, oa8, ob8, oa6, ob6);
    chk("oor_wr_a8", oa8, 16'h7777);
    chk("oor_wr_a6", oa6, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      do_round(1'b1, 1'b0, 3'(i), 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, oa8, ob8, oa6, ob6);
    end
    chk("oor_word3_a6", mem6[3], 16'hBEEF);
    do_round(1'b1, 1'b0, 3'd6, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, oa8, ob8, oa6, ob6);
    chk("oor_rd_a8", oa8, 16'h7777);
    chk("oor_rd_a6", oa6, 16'h0000);

    // randomized rounds against the model
    for (int r = 0; r < 40; r++) begin
      a_en = 1'($urandom_range(0, 1));
      b_en = 1'($urandom_range(0, 1));
      if (!a_en && !b_en) a_en = 1'b1;
      do_round(a_en, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
               b_en, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
               oa8, ob8, oa6, ob6);
    end

    // fairness: both held for six grants, three cycles apart, alternating
    first = ptr_m;
    req_a = 1'b1; we_a = 1'b0; addr_a = 3'd6; wdata_a = 16'h0000;
    req_b = 1'b1; we_b = 1'b0; addr_b = 3'd2; wdata_b = 16'h0000;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      gi = ((c % 3) == 2) ? (c - 2) / 3 : -1;
      chk1("fair_gnt_a8", gnt_a8, (gi >= 0) && ((first ^ gi[0]) == 1'b0));
      chk1("fair_gnt_b8", gnt_b8, (gi >= 0) && ((first ^ gi[0]) == 1'b1));
      chk1("fair_overlap6", gnt_a6 & gnt_b6, 1'b0);
      if (gi >= 0) begin
        if ((first ^ gi[0]) == 1'b0) begin
          model_acc(1'b0, 1'b0, 3'd6, 16'h0000, e8);
          model_acc(1'b1, 1'b0, 3'd6, 16'h0000, e6);
          chk("fair_rdata_a8", rdata_a8, e8); chk("fair_rdata_a6", rdata_a6, e6);
          last_ra8 = e8; last_ra6 = e6; ptr_m = 1'b1;
        end else begin
          model_acc(1'b0, 1'b0, 3'd2, 16'h0000, e8);
          model_acc(1'b1, 1'b0, 3'd2, 16'h0000, e6);
          chk("fair_rdata_b8", rdata_b8, e8); chk("fair_rdata_b6", rdata_b6, e6);
          last_rb8 = e8; last_rb6 = e6; ptr_m = 1'b0;
        end
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    chk1("fair_end_busy8", busy8, 1'b0);

    // reset during ACCESS aborts the write and clears the bank
    req_a = 1'b1; we_a = 1'b1; addr_a = 3'd1; wdata_a = 16'hCAFE;
    @(posedge clk); #1;
    chk1("midrst_access_busy8", busy8, 1'b1);
    rst_n = 1'b0; req_a = 1'b0;
    #1;
    chk1("midrst_busy8", busy8, 1'b0);
    chk1("midrst_gnt_a8", gnt_a8, 1'b0);
    @(posedge clk); #1;
    chk1("midrst_gnt_a8_hold", gnt_a8, 1'b0);
    chk("midrst_rdata_a8", rdata_a8, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem8[i] = 16'h0000;
      mem6[i] = 16'h0000;
    end
    ptr_m = 1'b0;
    last_ra8 = 16'h0000; last_rb8 = 16'h0000; last_ra6 = 16'h0000; last_rb6 = 16'h0000;
    @(posedge clk); #1;
    chk1("midrst_after_gnt_a8", gnt_a8, 1'b0);
    do_round(1'b1, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, oa8, ob8, oa6, ob6);
    chk("midrst_read1_a8", oa8, 16'h0000);
    chk("midrst_read1_a6", oa6, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
